// File: rtl/dla_pkg.sv
// dla_pkg: shared states, neighbour offsets, corner and LFSR seed constants for the DLA engine
package dla_pkg;
  typedef enum logic [3:0] {
    SEED, RD0, RD1, RD2, RD3, RD4, RD5, RD6, RD7, RD_LAST, EVAL, MOVE, STICK, SPAWN, DONE
  } state_t;
  localparam logic [30:0] LFSR_X_SEED = 31'h55555555;
  localparam logic [28:0] LFSR_Y_SEED = 29'h15555555;
  localparam logic [30:0] LFSR_S_SEED = 31'h2AAAAAAA;
  localparam logic [1:0] NB_DX [8] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11, 2'b01};
  localparam logic [1:0] NB_DY [8] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01};
  function automatic logic [17:0] pack_xy(input logic [8:0] x, input logic [8:0] y);
    return {x, y};
  endfunction
  function automatic logic [17:0] corner_xy(input logic [1:0] c, input int x_max, input int y_max, input int margin);
    return {c[0] ? 9'(x_max - margin) : 9'(margin), c[1] ? 9'(y_max - margin) : 9'(margin)};
  endfunction
endpackage

// File: rtl/dla_engine_multi_lfsr.sv
// dla_lfsr: Fibonacci LFSR with two feedback taps and a synchronous reseed
module dla_lfsr #(
  parameter int WIDTH = 31,
  parameter int TAP_A = 30,
  parameter int TAP_B = 27,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  // shift left, feeding the xor of the two taps into bit 0
  always_ff @(posedge clk) q <= reset ? SEED : en ? {q[WIDTH-2:0], q[TAP_A] ^ q[TAP_B]} : q;
endmodule

// File: rtl/dla_engine_multi.sv
// dla_engine_multi: round-robin multi-walker DLA engine that owns the SRAM only during VGA sync windows
module dla_engine_multi
  import dla_pkg::*;
#(
  parameter int N_WALKERS     = 4,
  parameter int CONNECT       = 4,
  parameter int X_MAX         = 319,
  parameter int Y_MAX         = 239,
  parameter int MARGIN        = 2,
  parameter int MAX_PARTICLES = 20000,
  parameter int STICK_THRESH  = 255
) (
  input  logic        VGA_CTRL_CLK,
  input  logic        reset,
  input  logic        i_sync_win,
  input  logic        i_run,
  input  logic [17:0] i_vga_addr,
  input  logic [17:0] i_start_xy,
  input  logic [15:0] i_color,
  input  logic [15:0] i_sram_rdata,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  output logic        o_sram_we_n,
  output logic [15:0] o_count,
  output logic        o_done
);
  localparam int IW = N_WALKERS > 1 ? $clog2(N_WALKERS) : 1;
  localparam logic [8:0] XLO = 9'(MARGIN);
  localparam logic [8:0] XHI = 9'(X_MAX - MARGIN);
  localparam logic [8:0] YLO = 9'(MARGIN);
  localparam logic [8:0] YHI = 9'(Y_MAX - MARGIN);
  state_t st_q, st_d;
  logic lock_q, lock_d, en_xy, en_s, engine, rbit, unused_bits;
  logic [3:0] sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d, idx_nx;
  logic [15:0] count_q, count_d;
  logic [17:0] start_q;
  logic [8:0] wx_q [N_WALKERS];
  logic [8:0] wy_q [N_WALKERS];
  logic [8:0] wx_d [N_WALKERS];
  logic [8:0] wy_d [N_WALKERS];
  logic [8:0] cx, cy, nx, ny;
  logic [2:0] rd_k;
  logic [30:0] lx, ls;
  logic [28:0] ly;
  dla_lfsr #(.WIDTH(31), .TAP_A(30), .TAP_B(27), .SEED(LFSR_X_SEED)) u_lfsr_x (.clk(VGA_CTRL_CLK), .reset(reset), .en(en_xy), .q(lx));
  dla_lfsr #(.WIDTH(29), .TAP_A(28), .TAP_B(26), .SEED(LFSR_Y_SEED)) u_lfsr_y (.clk(VGA_CTRL_CLK), .reset(reset), .en(en_xy), .q(ly));
  dla_lfsr #(.WIDTH(31), .TAP_A(30), .TAP_B(27), .SEED(LFSR_S_SEED)) u_lfsr_s (.clk(VGA_CTRL_CLK), .reset(reset), .en(en_s), .q(ls));
  assign engine = ~reset & i_sync_win & i_run;
  assign rbit = i_sram_rdata[15];
  assign unused_bits = ^{ls[30:8], lx[29:0], ly[27:0], i_sram_rdata[14:0]};
  assign rd_k = 3'(st_q - RD0);
  assign cx = wx_q[idx_q];
  assign cy = wy_q[idx_q];
  assign nx = cx + {{7{NB_DX[rd_k][1]}}, NB_DX[rd_k]};
  assign ny = cy + {{7{NB_DY[rd_k][1]}}, NB_DY[rd_k]};
  assign idx_nx = idx_q == IW'(N_WALKERS - 1) ? '0 : idx_q + 1'b1;
  assign o_count = reset ? '0 : count_q;
  assign o_done = ~reset & (st_q == DONE);
  // next state, SRAM bus and walker updates; the bus falls back to display passthrough outside engine cycles
  always_comb begin
    st_d = st_q;
    lock_d = engine & lock_q;
    sum_d = sum_q;
    idx_d = idx_q;
    count_d = count_q;
    wx_d = wx_q;
    wy_d = wy_q;
    en_xy = 1'b0;
    en_s = 1'b0;
    o_sram_addr = i_vga_addr;
    o_sram_we_n = ~reset;
    o_sram_wdata = reset ? '0 : i_color;
    if (engine) begin
      case (st_q)
        SEED: begin
          o_sram_addr = start_q;
          o_sram_we_n = 1'b0;
          st_d = RD0;
        end
        RD_LAST: begin
          sum_d = sum_q + 4'(rbit);
          st_d = EVAL;
        end
        EVAL: begin
          en_s = 1'b1;
          st_d = !lock_q ? RD0 : (sum_q != 0 && int'(ls[7:0]) <= STICK_THRESH) ? STICK : MOVE;
        end
        MOVE: begin
          wx_d[idx_q] = (lx[30] && cx < XHI) ? cx + 9'd1 : (!lx[30] && cx > XLO) ? cx - 9'd1 : cx;
          wy_d[idx_q] = (ly[28] && cy < YHI) ? cy + 9'd1 : (!ly[28] && cy > YLO) ? cy - 9'd1 : cy;
          en_xy = 1'b1;
          idx_d = idx_nx;
          st_d = RD0;
        end
        STICK: begin
          o_sram_addr = pack_xy(cx, cy);
          o_sram_we_n = 1'b0;
          count_d = count_q + 16'd1;
          st_d = count_q + 16'd1 == 16'(MAX_PARTICLES) ? DONE : SPAWN;
        end
        SPAWN: begin
          {wx_d[idx_q], wy_d[idx_q]} = corner_xy({ly[28], lx[30]}, X_MAX, Y_MAX, MARGIN);
          en_xy = 1'b1;
          idx_d = idx_nx;
          st_d = RD0;
        end
        DONE: st_d = DONE;
        default: begin
          o_sram_addr = pack_xy(nx, ny);
          lock_d = (st_q == RD0) | lock_q;
          sum_d = st_q == RD0 ? '0 : sum_q + 4'(rbit);
          st_d = rd_k == 3'(CONNECT - 1) ? RD_LAST : state_t'(st_q + 4'd1);
        end
      endcase
    end
  end
  // state registers; reset parks walkers on their home corners and captures the seed pixel
  always_ff @(posedge VGA_CTRL_CLK) begin
    if (reset) begin
      st_q <= SEED;
      lock_q <= 1'b0;
      sum_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      start_q <= i_start_xy;
      for (int i = 0; i < N_WALKERS; i++) {wx_q[i], wy_q[i]} <= corner_xy(2'(i % 4), X_MAX, Y_MAX, MARGIN);
    end else begin
      st_q <= st_d;
      lock_q <= lock_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      count_q <= count_d;
      wx_q <= wx_d;
      wy_q <= wy_d;
    end
  end
endmodule
